vram_write_arbiter: RTL and testbench

Owns the single write port of the 80x60 character RAM and shares it between two requesters: CPU character stores and a hardware fill engine (screen clear / fill with one character). CPU stores are buffered in a small FIFO so the CPU is never stalled by a fill. The block sits between the CPU bus decode (wvram path) and the char RAM, driving its write enable, address and data.

---
 rtl/vram_write_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vram_write_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_arbiter.sv
// Single write port owner for the 80x60 char RAM: a small FIFO buffers CPU stores, which preempt a
// screen fill engine. Build macro VRAM_BLANK_ONLY_WRITE_EN restricts grants to VGA blanking.
module vram_write_arbiter #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned DATA_W     = 7,
    parameter int unsigned DEPTH      = 4800,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_full,
    output logic              cpu_ovf,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_char,
    output logic              fill_busy,
    output logic              fill_done,
    input  logic              vga_blank,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCpu  = 2'b01,
        StFill = 2'b10
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_d;
    logic              r_cpu_full;
    logic              r_cpu_ovf;
    logic              r_fill_busy;
    logic [ADDR_W-1:0] r_fill_addr;
    logic [DATA_W-1:0] r_fill_char;
    logic              r_fill_last_wr;
    logic              r_fill_done;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic              w_grant_ok;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_fill_go;
    logic              w_fill_last;

`ifdef VRAM_BLANK_ONLY_WRITE_EN
    assign w_grant_ok = vga_blank;
`else
    logic w_unused_blank;
    assign w_unused_blank = vga_blank;
    assign w_grant_ok     = 1'b1;
`endif

    assign w_fifo_empty = (r_count == '0);
    assign w_fill_last  = (r_fill_addr == ADDR_W'(DEPTH - 1));

    // Grant for this cycle; the registered state is what ram_we reflects.
    always_comb begin
        w_state_d = StIdle;
        if (w_grant_ok && !w_fifo_empty) begin
            w_state_d = StCpu;
        end else if (w_grant_ok && r_fill_busy) begin
            w_state_d = StFill;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    assign w_pop     = (w_state_d == StCpu);
    assign w_fill_go = (w_state_d == StFill);
    assign w_push    = cpu_wr && (!r_cpu_full || w_pop);

    always_comb begin
        w_count_d = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CNT_W'(1);
            2'b01:   w_count_d = r_count - CNT_W'(1);
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= cpu_addr;
            r_fifo_data[r_wr_ptr] <= cpu_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_cpu_full     <= 1'b0;
            r_cpu_ovf      <= 1'b0;
            r_fill_busy    <= 1'b0;
            r_fill_addr    <= '0;
            r_fill_char    <= '0;
            r_fill_last_wr <= 1'b0;
            r_fill_done    <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_data     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_d;
            r_cpu_full <= (w_count_d == CNT_W'(FIFO_DEPTH));
            if (cpu_wr && !w_push) begin
                r_cpu_ovf <= 1'b1;
            end
            // fill_done trails the last write by one cycle so it lines up after ram_we shows it.
            r_fill_last_wr <= w_fill_go && w_fill_last;
            r_fill_done    <= r_fill_last_wr;
            if (w_pop) begin
                r_ram_addr <= r_fifo_addr[r_rd_ptr];
                r_ram_data <= r_fifo_data[r_rd_ptr];
            end else if (w_fill_go) begin
                r_ram_addr <= r_fill_addr;
                r_ram_data <= r_fill_char;
            end
            if (w_fill_go) begin
                r_fill_addr <= r_fill_addr + ADDR_W'(1);
                if (w_fill_last) begin
                    r_fill_busy <= 1'b0;
                end
            end else if (fill_start && !r_fill_busy) begin
                r_fill_busy <= 1'b1;
                r_fill_addr <= '0;
                r_fill_char <= fill_char;
            end
        end
    end

    assign ram_we    = (r_state != StIdle);
    assign ram_addr  = r_ram_addr;
    assign ram_data  = r_ram_data;
    assign cpu_full  = r_cpu_full;
    assign cpu_ovf   = r_cpu_ovf;
    assign fill_busy = r_fill_busy;
    assign fill_done = r_fill_done;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: vector table, directed fill/CPU/reset sequences and
// randomized traffic against a queue-based reference model.
module tb_vram_write_arbiter;
    localparam int DEPTH = 4800;
    localparam int FD    = 4;

    logic        clk_sys = 1'b0;
    logic        rst, cpu_wr, fill_start, vga_blank;
    logic [12:0] cpu_addr;
    logic [6:0]  cpu_data, fill_char;
    logic        cpu_full, cpu_ovf, fill_busy, fill_done, ram_we;
    logic [12:0] ram_addr;
    logic [6:0]  ram_data;

    always #5 clk_sys = ~clk_sys;

    vram_write_arbiter dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_full   (cpu_full),
        .cpu_ovf    (cpu_ovf),
        .fill_start (fill_start),
        .fill_char  (fill_char),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .vga_blank  (vga_blank),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data)
    );

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [12:0] a;
        logic [6:0]  d;
    } wr_t;

    // Reference model: expected DUT outputs after the most recent edge.
    wr_t         m_q[$];
    bit          m_busy, m_we, m_full, m_ovf, m_done, m_last;
    int          m_fa;
    logic [6:0]  m_fc, m_data;
    logic [12:0] m_addr;

    // Independent fill/CPU monitor for the directed sequences.
    bit          mon_on;
    logic [6:0]  mon_char;
    int          mon_next, mon_bad, mon_done;
    logic [12:0] mon_cpu[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_update();
        bit  ok, pop, go, busy_old;
        wr_t e;
        ok = 1'b1;
`ifdef VRAM_BLANK_ONLY_WRITE_EN
        ok = vga_blank;
`endif
        if (rst) begin
            m_q.delete();
            m_busy = 0; m_fa = 0; m_fc = '0; m_we = 0; m_addr = '0; m_data = '0;
            m_full = 0; m_ovf = 0; m_done = 0; m_last = 0;
            return;
        end
        pop      = ok && (m_q.size() != 0);
        go       = ok && !pop && m_busy;
        busy_old = m_busy;
        m_we     = pop || go;
        if (pop) begin
            e = m_q.pop_front();
            m_addr = e.a;
            m_data = e.d;
        end else if (go) begin
            m_addr = 13'(m_fa);
            m_data = m_fc;
        end
        m_done = m_last;
        m_last = go && (m_fa == DEPTH - 1);
        if (go) begin
            if (m_fa == DEPTH - 1) m_busy = 0;
            m_fa++;
        end
        if (cpu_wr) begin
            if (m_q.size() < FD) m_q.push_back('{cpu_addr, cpu_data});
            else m_ovf = 1;
        end
        if (fill_start && !busy_old) begin
            m_busy = 1; m_fa = 0; m_fc = fill_char;
        end
        m_full = (m_q.size() == FD);
    endtask

    task automatic step();
        model_update();
        @(posedge clk_sys);
        #1;
        chk("model.ram_we", 32'(ram_we), 32'(m_we));
        chk("model.ram_addr", 32'(ram_addr), 32'(m_addr));
        chk("model.ram_data", 32'(ram_data), 32'(m_data));
        chk("model.cpu_full", 32'(cpu_full), 32'(m_full));
        chk("model.cpu_ovf", 32'(cpu_ovf), 32'(m_ovf));
        chk("model.fill_busy", 32'(fill_busy), 32'(m_busy));
        chk("model.fill_done", 32'(fill_done), 32'(m_done));
        if (mon_on) begin
            if (fill_done) mon_done++;
            if (ram_we) begin
                if (ram_data == mon_char) begin
                    if (ram_addr != 13'(mon_next)) mon_bad++;
                    mon_next++;
                end else begin
                    mon_cpu.push_back(ram_addr);
                end
            end
        end
    endtask

    task automatic wait_fill_addr(input int a, input int budget);
        bit hit = 0;
        for (int c = 0; c < budget && !hit; c++) begin
            step();
            if (ram_we && ram_addr == 13'(a)) hit = 1;
        end
        chk($sformatf("wait_addr_%0d", a), 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    typedef struct {
        bit          rst, wr, fs, we, busy;
        logic [12:0] a, ea;
        logic [6:0]  d, fc, ed;
    } vec_t;

    function automatic vec_t mk(int r, int w, int a, int d, int fs, int fc,
                                int we, int ea, int ed, int bz);
        vec_t v;
        v.rst = r[0]; v.wr = w[0]; v.a = a[12:0]; v.d = d[6:0]; v.fs = fs[0]; v.fc = fc[6:0];
        v.we = we[0]; v.ea = ea[12:0]; v.ed = ed[6:0]; v.busy = bz[0];
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        logic [12:0] got[$];
        bit prev_last;
        int nxt, ndone, bad;
        bit saw_full;

        rst = 0; cpu_wr = 0; cpu_addr = '0; cpu_data = '0;
        fill_start = 0; fill_char = '0; vga_blank = 1;
        mon_on = 0; mon_char = '0; mon_next = 0; mon_bad = 0; mon_done = 0;

        //          rst wr  addr    data  fs fc    we  eaddr   edata busy
        tbl[0]  = mk(1, 0, 0,     0,    0, 0,    0, 0,     0,    0);
        tbl[1]  = mk(0, 1, 'h0A3, 'h41, 0, 0,    0, 0,     0,    0);
        tbl[2]  = mk(0, 0, 0,     0,    0, 0,    1, 'h0A3, 'h41, 0);
        tbl[3]  = mk(0, 0, 0,     0,    0, 0,    0, 'h0A3, 'h41, 0);
        tbl[4]  = mk(0, 1, 'h010, 'h11, 0, 0,    0, 'h0A3, 'h41, 0);
        tbl[5]  = mk(0, 1, 'h011, 'h12, 0, 0,    1, 'h010, 'h11, 0);
        tbl[6]  = mk(0, 0, 0,     0,    0, 0,    1, 'h011, 'h12, 0);
        tbl[7]  = mk(0, 0, 0,     0,    0, 0,    0, 'h011, 'h12, 0);
        tbl[8]  = mk(0, 1, 'h123, 'h55, 1, 'h2A, 0, 'h011, 'h12, 1);
        tbl[9]  = mk(0, 0, 0,     0,    0, 0,    1, 'h123, 'h55, 1);
        tbl[10] = mk(0, 0, 0,     0,    0, 0,    1, 'h000, 'h2A, 1);
        tbl[11] = mk(1, 0, 0,     0,    0, 0,    0, 0,     0,    0);
        tbl[12] = mk(0, 0, 0,     0,    0, 0,    0, 0,     0,    0);

        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; cpu_wr = tbl[i].wr; cpu_addr = tbl[i].a; cpu_data = tbl[i].d;
            fill_start = tbl[i].fs; fill_char = tbl[i].fc;
            step();
            chk($sformatf("vec%0d.we", i), 32'(ram_we), 32'(tbl[i].we));
            chk($sformatf("vec%0d.addr", i), 32'(ram_addr), 32'(tbl[i].ea));
            chk($sformatf("vec%0d.data", i), 32'(ram_data), 32'(tbl[i].ed));
            chk($sformatf("vec%0d.busy", i), 32'(fill_busy), 32'(tbl[i].busy));
            rst = 0; cpu_wr = 0; fill_start = 0;
        end

        // Burst of six stores.
        got.delete();
        saw_full = 0;
`ifdef VRAM_BLANK_ONLY_WRITE_EN
        vga_blank = 0;
`endif
        for (int i = 0; i < 6; i++) begin
            cpu_wr = 1; cpu_addr = 13'(32'h200 + i); cpu_data = 7'(32'h10 + i);
            step();
            if (cpu_full) saw_full = 1;
            if (ram_we) got.push_back(ram_addr);
        end
        cpu_wr = 0;
`ifdef VRAM_BLANK_ONLY_WRITE_EN
        chk("burst.full", 32'(cpu_full), 32'd1);
        chk("burst.ovf", 32'(cpu_ovf), 32'd1);
        chk("burst.stalled_writes", 32'(got.size()), 32'd0);
        vga_blank = 1;
`endif
        for (int c = 0; c < 10; c++) begin
            step();
            if (ram_we) got.push_back(ram_addr);
        end
`ifdef VRAM_BLANK_ONLY_WRITE_EN
        chk("burst.count", 32'(got.size()), 32'd4);
`else
        chk("burst.full_seen", 32'(saw_full), 32'd0);
        chk("burst.ovf", 32'(cpu_ovf), 32'd0);
        chk("burst.count", 32'(got.size()), 32'd6);
`endif
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("burst.order%0d", i), 32'(got[i]), 32'h200 + i);
        do_reset();

        // Complete fill with 0x20.
        fill_start = 1; fill_char = 7'h20; step(); fill_start = 0; fill_char = '0;
        nxt = 0; ndone = 0; bad = 0; prev_last = 0;
        for (int c = 0; c < DEPTH + 20; c++) begin
            step();
            if (fill_done) begin
                ndone++;
                chk("fill.done_after_last", 32'(prev_last), 32'd1);
            end
            prev_last = ram_we && (ram_addr == 13'(DEPTH - 1));
            if (ram_we) begin
                if (ram_addr != 13'(nxt) || ram_data != 7'h20) bad++;
                nxt++;
            end
        end
        chk("fill.writes", 32'(nxt), 32'(DEPTH));
        chk("fill.bad", 32'(bad), 32'd0);
        chk("fill.done_count", 32'(ndone), 32'd1);
        chk("fill.busy_end", 32'(fill_busy), 32'd0);

        // Fill with CPU interleave at 100 and an ignored restart at 50.
        mon_on = 1; mon_char = 7'h2E; mon_next = 0; mon_bad = 0; mon_done = 0; mon_cpu.delete();
        fill_start = 1; fill_char = 7'h2E; step(); fill_start = 0;
        wait_fill_addr(49, 200);
        fill_start = 1; fill_char = 7'h33; step(); fill_start = 0; fill_char = '0;
        wait_fill_addr(99, 200);
        for (int i = 0; i < 3; i++) begin
            cpu_wr = 1; cpu_addr = 13'(32'h1000 + i); cpu_data = 7'(32'h7F - i);
            step();
        end
        cpu_wr = 0;
        for (int c = 0; c < DEPTH + 20 && mon_done == 0; c++) step();
        for (int c = 0; c < 5; c++) step();
        mon_on = 0;
        chk("mid.fill_writes", 32'(mon_next), 32'(DEPTH));
        chk("mid.gaps", 32'(mon_bad), 32'd0);
        chk("mid.done_count", 32'(mon_done), 32'd1);
        chk("mid.cpu_count", 32'(mon_cpu.size()), 32'd3);
        for (int i = 0; i < mon_cpu.size(); i++)
            chk($sformatf("mid.cpu%0d", i), 32'(mon_cpu[i]), 32'h1000 + i);

        // Reset mid-fill at address 2000.
        fill_start = 1; fill_char = 7'h41; step(); fill_start = 0;
        wait_fill_addr(1999, 2500);
        do_reset();
        chk("rst.we", 32'(ram_we), 32'd0);
        chk("rst.busy", 32'(fill_busy), 32'd0);
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (fill_done || ram_we) ndone++;
        end
        chk("rst.quiet", 32'(ndone), 32'd0);
        fill_start = 1; fill_char = 7'h42; step(); fill_start = 0;
        step();
        chk("rst.refill_we", 32'(ram_we), 32'd1);
        chk("rst.refill_addr", 32'(ram_addr), 32'd0);
        chk("rst.refill_data", 32'(ram_data), 32'h42);
        do_reset();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 999) == 0);
            cpu_wr     = ($urandom_range(0, 2) == 0);
            cpu_addr   = 13'($urandom);
            cpu_data   = 7'($urandom);
            fill_start = ($urandom_range(0, 149) == 0);
            fill_char  = 7'($urandom);
            vga_blank  = ($urandom_range(0, 1) == 0);
            step();
        end
        rst = 0; cpu_wr = 0; fill_start = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
